n64_poll: RTL and testbench

N64_POLL -- requirements
Module: n64_poll

---
 rtl/n64_poll.sv | 248 ++++++++++++++++++++++++
 tb/tb_n64_poll.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_poll.sv
// n64_poll: periodic N64 controller poller.
// Sends the status command 8'h01 on the open-drain joybus line, then decodes
// the controller's 32-bit reply. First wire byte ends up in cntlr_data[7:0].
// Every state is timed in whole microseconds from the moment it was entered.
module n64_poll #(
    parameter int CYC_PER_US = 50,
    parameter int POLL_US    = 16000,
    parameter int TIMEOUT_US = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_in,
    output logic        data_oe,
    output logic [31:0] cntlr_data,
    output logic        set_cntlr_data_rdy,
    output logic        err
);

    localparam int CW     = $clog2(CYC_PER_US);
    localparam int MAXUS0 = (POLL_US > TIMEOUT_US) ? POLL_US : TIMEOUT_US;
    localparam int MAXUS  = (MAXUS0 > 3) ? MAXUS0 : 3;
    // One spare bit so the saturated value sits above every compare point.
    localparam int UW     = $clog2(MAXUS + 1) + 1;

    localparam logic [CW-1:0] CYC_LAST  = CW'(CYC_PER_US - 1);
    localparam logic [UW-1:0] POLL_LAST = UW'(POLL_US - 1);
    localparam logic [UW-1:0] TO_LAST   = UW'(TIMEOUT_US - 1);
    localparam logic [UW-1:0] US_0      = UW'(0);
    localparam logic [UW-1:0] US_1      = UW'(1);
    localparam logic [UW-1:0] US_2      = UW'(2);

    typedef enum logic [2:0] {
        IDLE,
        TX_LOW,
        TX_HIGH,
        TX_STOP,
        RX_EDGE,
        RX_SAMPLE,
        RX_STOP,
        DONE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cyc_cnt_reg;
    logic [UW-1:0]   us_cnt_reg;
    logic [7:0]      tx_sr_reg;
    logic [2:0]      tx_cnt_reg;
    logic [31:0]     rx_sr_reg;
    logic [4:0]      rx_cnt_reg;
    logic            phase_reg;
    logic            data_oe_reg;
    logic [31:0]     cntlr_data_reg;
    logic            rdy_reg;
    logic            err_reg;

    logic            ds_meta_reg;
    logic            ds_reg;
    logic            ds_prev_reg;

    logic            us_tick;
    logic            ds_fall;
    logic            timeout;
    logic            tx_bit;
    logic [UW-1:0]   low_last;
    logic [UW-1:0]   high_last;
    logic [31:0]     rx_swapped;

    assign data_oe            = data_oe_reg;
    assign cntlr_data         = cntlr_data_reg;
    assign set_cntlr_data_rdy = rdy_reg;
    assign err                = err_reg;

    assign us_tick   = (cyc_cnt_reg == CYC_LAST);
    assign ds_fall   = ds_prev_reg & ~ds_reg;
    assign timeout   = us_tick && (us_cnt_reg >= TO_LAST);
    assign tx_bit    = tx_sr_reg[7];
    // A '1' is 1 us low / 3 us high, a '0' is 3 us low / 1 us high.
    assign low_last  = tx_bit ? US_0 : US_2;
    assign high_last = tx_bit ? US_2 : US_0;

    // The wire delivers bytes MSB-first with the first byte landing in the top
    // of rx_sr_reg; reverse byte order so the first byte sits in [7:0].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_swap
            assign rx_swapped[gi*8 +: 8] = rx_sr_reg[(3-gi)*8 +: 8];
        end
    endgenerate

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            ds_meta_reg <= 1'b1;
            ds_reg      <= 1'b1;
            ds_prev_reg <= 1'b1;
        end else begin
            ds_meta_reg <= data_in;
            ds_reg      <= ds_meta_reg;
            ds_prev_reg <= ds_reg;
        end
    end

    // Protocol FSM with microsecond timebase; timers restart on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cyc_cnt_reg    <= '0;
            us_cnt_reg     <= '0;
            tx_sr_reg      <= '0;
            tx_cnt_reg     <= '0;
            rx_sr_reg      <= '0;
            rx_cnt_reg     <= '0;
            phase_reg      <= 1'b0;
            data_oe_reg    <= 1'b0;
            cntlr_data_reg <= '0;
            rdy_reg        <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            rdy_reg <= 1'b0;
            err_reg <= 1'b0;

            // Free-running timebase; the microsecond count saturates.
            if (us_tick) begin
                cyc_cnt_reg <= '0;
                if (us_cnt_reg != '1) begin
                    us_cnt_reg <= us_cnt_reg + US_1;
                end
            end else begin
                cyc_cnt_reg <= cyc_cnt_reg + CW'(1);
            end

            case (state_reg)
                IDLE: begin
                    data_oe_reg <= 1'b0;
                    if (us_tick && us_cnt_reg == POLL_LAST) begin
                        tx_sr_reg   <= 8'h01;
                        tx_cnt_reg  <= '0;
                        data_oe_reg <= 1'b1;
                        state_reg   <= TX_LOW;
                        cyc_cnt_reg <= '0;
                        us_cnt_reg  <= '0;
                    end
                end

                TX_LOW: begin
                    if (us_tick && us_cnt_reg == low_last) begin
                        data_oe_reg <= 1'b0;
                        state_reg   <= TX_HIGH;
                        cyc_cnt_reg <= '0;
                        us_cnt_reg  <= '0;
                    end
                end

                TX_HIGH: begin
                    if (us_tick && us_cnt_reg == high_last) begin
                        data_oe_reg <= 1'b1;
                        cyc_cnt_reg <= '0;
                        us_cnt_reg  <= '0;
                        if (tx_cnt_reg == 3'd7) begin
                            state_reg <= TX_STOP;
                        end else begin
                            tx_sr_reg  <= {tx_sr_reg[6:0], 1'b0};
                            tx_cnt_reg <= tx_cnt_reg + 3'd1;
                            state_reg  <= TX_LOW;
                        end
                    end
                end

                TX_STOP: begin
                    if (us_tick && us_cnt_reg == US_0) begin
                        data_oe_reg <= 1'b0;
                        rx_cnt_reg  <= '0;
                        state_reg   <= RX_EDGE;
                        cyc_cnt_reg <= '0;
                        us_cnt_reg  <= '0;
                    end
                end

                RX_EDGE: begin
                    if (ds_fall) begin
                        phase_reg   <= 1'b0;
                        state_reg   <= RX_SAMPLE;
                        cyc_cnt_reg <= '0;
                        us_cnt_reg  <= '0;
                    end else if (timeout) begin
                        err_reg     <= 1'b1;
                        state_reg   <= IDLE;
                        cyc_cnt_reg <= '0;
                        us_cnt_reg  <= '0;
                    end
                end

                RX_SAMPLE: begin
                    // phase 0: waiting for the 2 us sample point; phase 1: waiting for high.
                    if (!phase_reg && us_tick && us_cnt_reg == US_1) begin
                        rx_sr_reg <= {rx_sr_reg[30:0], ds_reg};
                        phase_reg <= 1'b1;
                    end else if (phase_reg && ds_reg) begin
                        rx_cnt_reg  <= rx_cnt_reg + 5'd1;
                        phase_reg   <= 1'b0;
                        state_reg   <= (rx_cnt_reg == 5'd31) ? RX_STOP : RX_EDGE;
                        cyc_cnt_reg <= '0;
                        us_cnt_reg  <= '0;
                    end else if (timeout) begin
                        err_reg     <= 1'b1;
                        state_reg   <= IDLE;
                        cyc_cnt_reg <= '0;
                        us_cnt_reg  <= '0;
                    end
                end

                RX_STOP: begin
                    // phase 0: waiting for the stop-bit fall; phase 1: waiting for release.
                    if (!phase_reg && ds_fall) begin
                        phase_reg <= 1'b1;
                    end else if (phase_reg && ds_reg) begin
                        phase_reg   <= 1'b0;
                        state_reg   <= DONE;
                        cyc_cnt_reg <= '0;
                        us_cnt_reg  <= '0;
                    end else if (timeout) begin
                        phase_reg   <= 1'b0;
                        err_reg     <= 1'b1;
                        state_reg   <= IDLE;
                        cyc_cnt_reg <= '0;
                        us_cnt_reg  <= '0;
                    end
                end

                DONE: begin
                    cntlr_data_reg <= rx_swapped;
                    rdy_reg        <= 1'b1;
                    state_reg      <= IDLE;
                    cyc_cnt_reg    <= '0;
                    us_cnt_reg     <= '0;
                end

                default: begin
                    data_oe_reg <= 1'b0;
                    state_reg   <= IDLE;
                    cyc_cnt_reg <= '0;
                    us_cnt_reg  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n64_poll.sv
// tb_n64_poll: scoreboard bench for n64_poll with a joybus controller model.
module tb_n64_poll;

    localparam int CYC = 4;
    localparam int POLL = 10;
    localparam int TO = 8;

    typedef struct packed {
        logic        is_err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl_low = 1'b0;
    logic        data_in;
    logic        data_oe;
    logic [31:0] cntlr_data;
    logic        rdy;
    logic        err;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          rdy_seen = 0;
    int          err_seen = 0;
    int          rdy_exp = 0;
    int          err_exp = 0;
    logic [31:0] held_exp = 32'h0;
    bit          ctrl_abort = 1'b0;
    int          ctrl_bit = 0;

    assign data_in = ~(data_oe | ctrl_low);

    always #5 clk = ~clk;

    n64_poll #(
        .CYC_PER_US (CYC),
        .POLL_US    (POLL),
        .TIMEOUT_US (TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .data_in            (data_in),
        .data_oe            (data_oe),
        .cntlr_data         (cntlr_data),
        .set_cntlr_data_rdy (rdy),
        .err                (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %08h required %08h", name, act, req);
        end
    endtask

    task automatic check_rng(input string name, input int v, input int lo, input int hi);
        tests++;
        if (v < lo || v > hi) begin
            fails++;
            $display("FAIL %s: got %0d required %0d..%0d", name, v, lo, hi);
        end
    endtask

    // Monitor: every rdy/err pulse pops the scoreboard and is compared.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (rdy || err)) begin
            if (rdy) rdy_seen++;
            if (err) err_seen++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: rdy=%0b err=%0b required no pulse", rdy, err);
            end else begin
                e = q.pop_front();
                check("pulse_kind", {30'd0, rdy, err}, e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) begin
                    check("cntlr_data", cntlr_data, e.data);
                    held_exp = e.data;
                end else begin
                    check("data_on_err", cntlr_data, held_exp);
                end
            end
        end
    end

    // Wait for the 9 low pulses (8 command bits + stop) to finish.
    task automatic wait_cmd(output bit ok);
        int   falls = 0;
        int   n = 0;
        logic prev;
        prev = data_oe;
        while (falls < 9 && n < 4000) begin
            @(negedge clk);
            n++;
            if (prev && !data_oe) falls++;
            prev = data_oe;
        end
        ok = (falls == 9);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL cmd_timeout: saw %0d command pulses required 9", falls);
        end
    endtask

    // Controller model: replies 2 us after the command with nbits of word, MSB first.
    task automatic respond(input logic [31:0] word, input int nbits);
        bit ok;
        int lowc;
        wait_cmd(ok);
        if (ok) begin
            repeat (8) @(negedge clk);
            for (int b = 0; b < nbits && !ctrl_abort; b++) begin
                ctrl_bit = b;
                lowc = word[31-b] ? 4 : 12;
                for (int c = 0; c < 16 && !ctrl_abort; c++) begin
                    ctrl_low = (c < lowc);
                    @(negedge clk);
                end
                ctrl_low = 1'b0;
                if ((b % 8) == 7 && !ctrl_abort) begin
                    #1;
                    check("hold_mid_rx", cntlr_data, held_exp);
                end
            end
            if (nbits == 32 && !ctrl_abort) begin
                ctrl_low = 1'b1;
                repeat (4) @(negedge clk);
            end
        end
        ctrl_low = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic txn(input logic [31:0] word, input int nbits, input logic is_err,
                       input logic [31:0] exp_data);
        exp_t e;
        e.is_err = is_err;
        e.data   = exp_data;
        q.push_back(e);
        if (is_err) err_exp++;
        else rdy_exp++;
        respond(word, nbits);
        wait_drain();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   w;
        exp_t e;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_data_oe", {31'd0, data_oe}, 32'd0);
        check("rst_cntlr_data", cntlr_data, 32'h0);
        check("rst_rdy", {31'd0, rdy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        // First poll with no controller attached.
        e.is_err = 1'b1;
        e.data   = 32'h0;
        q.push_back(e);
        err_exp++;
        rst = 1'b0;
        n = 0;
        while (!data_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_rng("first_rise", n, 37, 43);

        // Command waveform: 0x01 MSB first, then the stop bit.
        for (int i = 0; i < 9; i++) begin
            w = 0;
            while (data_oe && w < 100) begin
                @(negedge clk);
                w++;
            end
            check_rng($sformatf("low_width_%0d", i), w, (i < 7) ? 12 : 4, (i < 7) ? 12 : 4);
            if (i < 8) begin
                w = 0;
                while (!data_oe && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                check_rng($sformatf("high_width_%0d", i), w, (i < 7) ? 4 : 12, (i < 7) ? 4 : 12);
            end
        end

        // Silent controller: err 8 us after stop release, next poll 10 us later.
        n = 0;
        while (!err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_rng("err_delay", n, 31, 33);
        n = 0;
        while (!data_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_rng("repoll_delay", n, 39, 41);
        e.is_err = 1'b1;
        q.push_back(e);
        err_exp++;
        wait_drain();
        check("hold_after_silent", cntlr_data, 32'h0);

        // All-ones then all-zeros: second reception must not disturb cntlr_data.
        txn(32'hFFFF_FFFF, 32, 1'b0, 32'hFFFF_FFFF);
        txn(32'h0000_0000, 32, 1'b0, 32'h0000_0000);

        // Byte ordering.
        txn(32'h8000_0102, 32, 1'b0, 32'h0201_0080);

        // Controller gives up after 17 bits.
        txn(32'hA5C3_0F96, 17, 1'b1, 32'h0);
        check("hold_after_short", cntlr_data, 32'h0201_0080);

        // Reset during bit 20 of reception.
        ctrl_bit = 0;
        fork
            respond(32'h5A5A_5A5A, 32);
            begin
                n = 0;
                while (ctrl_bit != 20 && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                check_rng("reach_bit20", n, 0, 2999);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("midrst_data_oe", {31'd0, data_oe}, 32'd0);
                check("midrst_cntlr_data", cntlr_data, 32'h0);
                held_exp = 32'h0;
                ctrl_abort = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        ctrl_abort = 1'b0;

        // Clean transaction after the reset.
        txn(32'h1234_5678, 32, 1'b0, 32'h7856_3412);

        check("rdy_count", 32'(rdy_seen), 32'(rdy_exp));
        check("err_count", 32'(err_seen), 32'(err_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
